spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// ---------------------------------------------------------------------------
// spi_slave_rx
//
// Purpose:
//   SPI slave that sends and receives one full-duplex frame of DATA_W bits,
//   LSB first, in any of the four SPI modes. The master's serial clock,
//   slave select and data are asynchronous to sys_clock. They pass through
//   two-flop synchronizers, and every SPI edge is found by oversampling the
//   synchronized copies on sys_clock. The sclk frequency must be at most
//   sys_clock/8.
//
// Parameters:
//   DATA_W         frame length in bits (default 18)
//
// Ports:
//   sys_clock      system clock; all logic runs on its rising edge
//   reset          synchronous, active-high reset
//   spi_mode[1:0]  bit1 = CPOL, bit0 = CPHA; latched at frame start
//   sclk           serial clock from the master (asynchronous)
//   ss_n           slave select, active-low (asynchronous)
//   mosi           serial data from the master, LSB first
//   miso           serial data to the master, LSB first; 1 when not sending
//   tx_data        response word for the next frame
//   tx_load        single-cycle strobe that captures tx_data while tx_ready
//   tx_ready       high only while idle, when tx_load is accepted
//   rx_data        last completely received word (all ones after reset)
//   rx_data_valid  one-cycle pulse when rx_data has just been updated
//   frame_err      (optional) one-cycle pulse when ss_n rises mid-frame
//   busy           high while a frame is in progress
//
// Configuration:
//   SPI_SLAVE_FRAME_ERR_EN  when defined, adds the frame_err output and the
//                           logic that drives it. All other behaviour is
//                           identical with or without it.
// ---------------------------------------------------------------------------
module spi_slave_rx #(
    parameter int DATA_W = 18
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic [1:0]        spi_mode,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_data_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // -----------------------------------------------------------------------
    // Synchronizers and edge-detect history
    // -----------------------------------------------------------------------
    logic       sclk_meta;
    logic       sclk_sync;
    logic       sclk_prev;
    logic       ss_n_meta;
    logic       ss_n_sync;
    logic       ss_n_prev;
    logic       mosi_meta;
    logic       mosi_sync;
    logic [1:0] sync_vld;
    logic       ss_armed;

    // -----------------------------------------------------------------------
    // Frame datapath
    // -----------------------------------------------------------------------
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] tx_src;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_next;

    // -----------------------------------------------------------------------
    // Decoded events
    // -----------------------------------------------------------------------
    logic sclk_rise;
    logic sclk_fall;
    logic ss_fall;
    logic ss_rise;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic drive_edge;
    logic last_sample;
    logic abort_frame;

    // The synchronizer reset values make the bus look idle: ss_n high, sclk
    // low. sync_vld records when the second stage holds a real pin sample
    // instead of its reset value. ss_armed is set only after a real sample of
    // ss_n is high. If ss_n is already low when reset is released, the
    // pipeline moving from its reset 1 to the pin's 0 therefore does not count
    // as a falling edge. A new frame needs a real high-to-low transition.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            sclk_meta <= 1'b0;
            sclk_sync <= 1'b0;
            sclk_prev <= 1'b0;
            ss_n_meta <= 1'b1;
            ss_n_sync <= 1'b1;
            ss_n_prev <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            sync_vld  <= 2'b00;
            ss_armed  <= 1'b0;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_n_meta <= ss_n;
            ss_n_sync <= ss_n_meta;
            ss_n_prev <= ss_n_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            sync_vld  <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && ss_n_sync) begin
                ss_armed <= 1'b1;
            end
        end
    end

    // mosi and sclk go through synchronizers of the same depth. When an sclk
    // edge is detected, mosi_sync therefore still shows the data that was on
    // the pin at the raw edge.
    always_comb begin
        sclk_rise   = sclk_sync & ~sclk_prev;
        sclk_fall   = ~sclk_sync & sclk_prev;
        ss_fall     = ss_armed & ss_n_prev & ~ss_n_sync;
        ss_rise     = ~ss_n_prev & ss_n_sync;
        lead_edge   = mode_r[1] ? sclk_fall : sclk_rise;
        trail_edge  = mode_r[1] ? sclk_rise : sclk_fall;
        sample_edge = mode_r[0] ? trail_edge : lead_edge;
        drive_edge  = mode_r[0] ? lead_edge : trail_edge;
        last_sample = sample_edge && (bit_cnt == LAST_BIT);
        abort_frame = (state == ACTIVE) && ss_rise;
        rx_next     = {mosi_sync, rx_shift[DATA_W-1:1]};
        tx_src      = tx_load ? tx_data : tx_buf;
    end

    // FSM state register
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. If ss_n rises in the same cycle as the final sample,
    // the abort wins. The master has already released the slave, so the word
    // is not treated as delivered.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                end else if (last_sample) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs are decoded directly from the state. rx_data is written
    // on the edge that enters DONE, so the single DONE cycle is the cycle in
    // which rx_data already holds the new word.
    always_comb begin
        tx_ready      = (state == IDLE);
        busy          = (state != IDLE);
        rx_data_valid = (state == DONE);
    end

    // The tx buffer accepts a new word only while idle. It keeps that word
    // across frames, so every frame re-sends the last word loaded.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            tx_buf <= '1;
        end else if (tx_load && (state == IDLE)) begin
            tx_buf <= tx_data;
        end
    end

    // Frame datapath.
    // At frame start the mode is frozen and the tx word is copied into the
    // shifter. tx_src bypasses the buffer, so a tx_load in the same cycle as
    // the ss_n falling edge still goes out in this frame.
    // CPHA=0: bit0 goes on miso at once, and each trailing edge puts out the
    //         next bit.
    // CPHA=1: miso stays 1 until the first leading edge, and each leading
    //         edge puts out the next bit.
    // The tx shifter fills with ones from the top, so miso idles high once the
    // word has been sent.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            mode_r   <= 2'b00;
            bit_cnt  <= '0;
            tx_shift <= '1;
            rx_shift <= '1;
            rx_data  <= '1;
            miso     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    miso <= 1'b1;
                    if (ss_fall) begin
                        mode_r  <= spi_mode;
                        bit_cnt <= '0;
                        if (spi_mode[0]) begin
                            tx_shift <= tx_src;
                        end else begin
                            miso     <= tx_src[0];
                            tx_shift <= {1'b1, tx_src[DATA_W-1:1]};
                        end
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        miso <= 1'b1;
                    end else begin
                        if (sample_edge) begin
                            rx_shift <= rx_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                        if (last_sample) begin
                            rx_data <= rx_next;
                            miso    <= 1'b1;
                        end else if (drive_edge) begin
                            miso     <= tx_shift[0];
                            tx_shift <= {1'b1, tx_shift[DATA_W-1:1]};
                        end
                    end
                end
                default: begin
                    miso <= 1'b1;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // One-cycle pulse for each frame that the master ends early.
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort_frame;
        end
    end
`else
    // Without the error output, abort_frame only documents the abort
    // condition. The FSM decodes the abort itself.
    logic abort_unused;
    assign abort_unused = abort_frame;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_rx
//
// Purpose:
//   Directed bench for spi_slave_rx. It acts as an SPI master bit by bit,
//   with sclk running at sys_clock/16, and checks the results with immediate
//   assertions against hand-computed words.
//
// Ports:
//   none (top-level bench)
//
// Configuration:
//   SPI_SLAVE_FRAME_ERR_EN  when defined, frame_err is connected and its
//                           pulses are counted and checked as well.
// ---------------------------------------------------------------------------
module tb_spi_slave_rx;

    localparam int DATA_W = 18;
    localparam int HALF   = 8;

    logic              sys_clock;
    logic              reset;
    logic [1:0]        spi_mode;
    logic              sclk;
    logic              ss_n;
    logic              mosi;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_data_valid;
    logic              busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    logic              frame_err;
`endif

    int total = 0;
    int bad = 0;
    int valid_cnt = 0;
    int err_cnt = 0;

    logic [31:0] got;

    spi_slave_rx #(.DATA_W(DATA_W)) dut (
        .sys_clock     (sys_clock),
        .reset         (reset),
        .spi_mode      (spi_mode),
        .sclk          (sclk),
        .ss_n          (ss_n),
        .mosi          (mosi),
        .miso          (miso),
        .tx_data       (tx_data),
        .tx_load       (tx_load),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
`ifdef SPI_SLAVE_FRAME_ERR_EN
        .frame_err     (frame_err),
`endif
        .busy          (busy)
    );

    initial begin
        sys_clock = 1'b0;
        forever #5 sys_clock = ~sys_clock;
    end

    // Count strobes on the falling edge, well away from the edge that
    // changes them.
    always @(negedge sys_clock) begin
        if (rx_data_valid) valid_cnt++;
`ifdef SPI_SLAVE_FRAME_ERR_EN
        if (frame_err) err_cnt++;
`endif
    end

    // Stops the run if it ever hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clock);
    endtask

    task automatic load_tx(input logic [DATA_W-1:0] value);
        tx_data = value;
        tx_load = 1'b1;
        cycles(1);
        tx_load = 1'b0;
    endtask

    // Plays the master for nbits clock pulses and collects miso, LSB first.
    // With keep_ss set, ss_n stays low after the last pulse.
    task automatic spi_frame(input logic [1:0] mode, input logic [31:0] word,
                             input int nbits, input bit keep_ss,
                             output logic [31:0] rcv);
        logic cpol;
        logic cpha;
        cpol = mode[1];
        cpha = mode[0];
        rcv = '0;
        spi_mode = mode;
        sclk = cpol;
        mosi = 1'b0;
        cycles(HALF);
        ss_n = 1'b0;
        cycles(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi = word[i];
                cycles(HALF);
                rcv[i] = miso;
                sclk = ~cpol;
                cycles(HALF);
                sclk = cpol;
            end else begin
                cycles(HALF);
                sclk = ~cpol;
                mosi = word[i];
                cycles(HALF);
                rcv[i] = miso;
                sclk = cpol;
            end
        end
        cycles(HALF);
        if (!keep_ss) begin
            ss_n = 1'b1;
            cycles(2 * HALF);
        end
    endtask

    initial begin
        reset    = 1'b1;
        spi_mode = 2'b00;
        sclk     = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_data  = '0;
        tx_load  = 1'b0;
        cycles(3);

        // Outputs while reset is held
        check("rst_miso", 32'(miso), 32'h1);
        check("rst_rx_data", 32'(rx_data), 32'h3FFFF);
        check("rst_valid", 32'(rx_data_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h1);
        reset = 1'b0;
        cycles(4);

        // Mode 0 full-duplex frame
        check("idle_tx_ready", 32'(tx_ready), 32'h1);
        load_tx(18'h2A5A5);
        spi_frame(2'b00, 32'h15A5A, DATA_W, 1'b0, got);
        check("m0_rx", 32'(rx_data), 32'h15A5A);
        check("m0_tx", got, 32'h2A5A5);
        check("m0_valid_cnt", valid_cnt, 1);
        check("m0_busy_after", 32'(busy), 32'h0);

        // Modes 1, 2 and 3
        load_tx(18'h00001);
        spi_frame(2'b01, 32'h20000, DATA_W, 1'b0, got);
        check("m1_rx", 32'(rx_data), 32'h20000);
        check("m1_tx", got, 32'h00001);
        check("m1_valid_cnt", valid_cnt, 2);
        spi_frame(2'b10, 32'h20000, DATA_W, 1'b0, got);
        check("m2_rx", 32'(rx_data), 32'h20000);
        check("m2_tx", got, 32'h00001);
        check("m2_valid_cnt", valid_cnt, 3);
        spi_frame(2'b11, 32'h20000, DATA_W, 1'b0, got);
        check("m3_rx", 32'(rx_data), 32'h20000);
        check("m3_tx", got, 32'h00001);
        check("m3_valid_cnt", valid_cnt, 4);

        // ss_n raised after 9 bits
        spi_frame(2'b00, 32'h0AAAA, 9, 1'b0, got);
        check("abort_valid_cnt", valid_cnt, 4);
        check("abort_rx_kept", 32'(rx_data), 32'h20000);
        check("abort_tx_bits", {23'h0, got[8:0]}, 32'h001);
        check("abort_busy", 32'(busy), 32'h0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("abort_frame_err", err_cnt, 1);
`endif

        // tx_load and a mode change while busy are both ignored
        fork
            spi_frame(2'b00, 32'h0F0F0, DATA_W, 1'b0, got);
            begin
                cycles(60);
                check("busy_mid", 32'(busy), 32'h1);
                check("tx_ready_mid", 32'(tx_ready), 32'h0);
                load_tx(18'h3FFFE);
                spi_mode = 2'b11;
            end
        join
        check("busy_load_rx", 32'(rx_data), 32'h0F0F0);
        check("busy_load_tx", got, 32'h00001);
        spi_frame(2'b00, 32'h3C3C3, DATA_W, 1'b0, got);
        check("resend_rx", 32'(rx_data), 32'h3C3C3);
        check("resend_tx", got, 32'h00001);
        check("resend_valid_cnt", valid_cnt, 6);

        // Reset at bit 10 with ss_n still low
        spi_frame(2'b00, 32'h3FFFF, 10, 1'b1, got);
        check("pre_rst_busy", 32'(busy), 32'h1);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(2 * HALF);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_miso", 32'(miso), 32'h1);
        check("midrst_rx_data", 32'(rx_data), 32'h3FFFF);
        check("midrst_tx_ready", 32'(tx_ready), 32'h1);
        check("midrst_valid_cnt", valid_cnt, 6);
        ss_n = 1'b1;
        cycles(2 * HALF);
        spi_frame(2'b00, 32'h12345, DATA_W, 1'b0, got);
        check("post_rst_rx", 32'(rx_data), 32'h12345);
        check("post_rst_tx", got, 32'h3FFFF);
        check("post_rst_valid_cnt", valid_cnt, 7);

        // 20 pulses in one ss_n window
        load_tx(18'h15555);
        spi_frame(2'b00, 32'hABCDE, 20, 1'b0, got);
        check("over_rx", 32'(rx_data), 32'h2BCDE);
        check("over_valid_cnt", valid_cnt, 8);
        check("over_tx", {14'h0, got[17:0]}, 32'h15555);
        check("over_miso_tail", {30'h0, got[19:18]}, 32'h3);
`ifdef SPI_SLAVE_FRAME_ERR_EN
        check("final_frame_err", err_cnt, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
